// File: rtl/logic_stream_unit_if.sv
// Operand/result stream bundle for logic_stream_unit.
// master drives operands and out_ready; slave returns results.
interface logic_stream_unit_if #(
    parameter int WIDTH = 8
);
    localparam int PW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             acc_en;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] Y;
    logic             out_valid;
    logic             out_ready;
    logic             zero;
    logic [PW-1:0]    pcnt;
    logic [15:0]      res_cnt;

    modport master (
        output a, b, op, acc_en, in_valid, out_ready,
        input  in_ready, Y, out_valid, zero, pcnt, res_cnt
    );

    modport slave (
        input  a, b, op, acc_en, in_valid, out_ready,
        output in_ready, Y, out_valid, zero, pcnt, res_cnt
    );
endinterface

// File: rtl/logic_stream_unit.sv
// Bitwise logic unit with accumulator feeding an in-order result FIFO.
// Results are registered on accept; head status is derived from Y.
module logic_stream_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    logic_stream_unit_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [15:0]      r_res_cnt;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_in_ready;
    logic [WIDTH-1:0] w_left;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_y;
    logic [PW-1:0]    w_pcnt;

    assign w_empty    = (r_cnt == '0);
    assign w_full     = (r_cnt == CW'(DEPTH));
    assign w_pop      = !w_empty && bus.out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign w_in_ready = reset && (!w_full || w_pop);
    assign w_push     = bus.in_valid && w_in_ready;

    assign w_left = bus.acc_en ? r_acc : bus.a;

    always_comb begin
        w_res = w_left;
        unique case (bus.op)
            3'd0: w_res = w_left & bus.b;
            3'd1: w_res = w_left | bus.b;
            3'd2: w_res = w_left ^ bus.b;
            3'd3: w_res = ~(w_left & bus.b);
            3'd4: w_res = ~(w_left | bus.b);
            3'd5: w_res = ~(w_left ^ bus.b);
            3'd6: w_res = w_left & ~bus.b;
            3'd7: w_res = w_left;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wp      <= '0;
            r_rp      <= '0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_res_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wp  <= r_wp + AW'(1);
                r_acc <= w_res;
            end
            if (w_pop) begin
                r_rp      <= r_rp + AW'(1);
                r_res_cnt <= r_res_cnt + 16'd1;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + CW'(1);
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    // Storage needs no reset: Y is gated by the occupancy count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= w_res;
        end
    end

    assign w_y = w_empty ? '0 : r_mem[r_rp];

    always_comb begin
        w_pcnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pcnt = w_pcnt + PW'(w_y[i]);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = !w_empty;
    assign bus.Y         = w_y;
    assign bus.zero      = !w_empty && (w_y == '0);
    assign bus.pcnt      = w_pcnt;
    assign bus.res_cnt   = r_res_cnt;
endmodule

// File: tb/tb_logic_stream_unit.sv
// Bench for logic_stream_unit: two configurations share one stimulus,
// each tracked by a queue model; directed literals pin the model.
module tb_logic_stream_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] sa = '0;
    logic [31:0] sb = '0;
    logic [2:0]  sop = '0;
    logic        sae = 1'b0;
    logic        siv = 1'b0;
    logic        sor = 1'b0;
    logic        chk_en = 1'b0;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    logic_stream_unit_if #(.WIDTH(8))  if8 ();
    logic_stream_unit_if #(.WIDTH(32)) if32 ();

    assign if8.a         = sa[7:0];
    assign if8.b         = sb[7:0];
    assign if8.op        = sop;
    assign if8.acc_en    = sae;
    assign if8.in_valid  = siv;
    assign if8.out_ready = sor;
    assign if32.a         = sa;
    assign if32.b         = sb;
    assign if32.op        = sop;
    assign if32.acc_en    = sae;
    assign if32.in_valid  = siv;
    assign if32.out_ready = sor;

    logic_stream_unit #(.WIDTH(8), .DEPTH(2)) u8 (
        .clk(clk), .reset(rst), .bus(if8)
    );
    logic_stream_unit #(.WIDTH(32), .DEPTH(4)) u32 (
        .clk(clk), .reset(rst), .bus(if32)
    );

    logic [31:0] ay [2];
    logic        av [2];
    logic        az [2];
    logic        air [2];
    logic [7:0]  apc [2];
    logic [15:0] arc [2];

    assign ay[0]  = {24'b0, if8.Y};
    assign ay[1]  = if32.Y;
    assign av[0]  = if8.out_valid;
    assign av[1]  = if32.out_valid;
    assign az[0]  = if8.zero;
    assign az[1]  = if32.zero;
    assign air[0] = if8.in_ready;
    assign air[1] = if32.in_ready;
    assign apc[0] = {4'b0, if8.pcnt};
    assign apc[1] = {2'b0, if32.pcnt};
    assign arc[0] = if8.res_cnt;
    assign arc[1] = if32.res_cnt;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] ref_op(logic [31:0] l, logic [31:0] r, logic [2:0] op);
        case (op)
            3'd0: return l & r;
            3'd1: return l | r;
            3'd2: return l ^ r;
            3'd3: return ~(l & r);
            3'd4: return ~(l | r);
            3'd5: return ~(l ^ r);
            3'd6: return l & ~r;
            default: return l;
        endcase
    endfunction

    logic [31:0] mq [2][$];
    logic [31:0] macc [2] = '{32'h0, 32'h0};
    logic [15:0] mrc [2] = '{16'h0, 16'h0};
    logic [31:0] mmask [2] = '{32'h0000_00FF, 32'hFFFF_FFFF};
    int          mdep [2] = '{2, 4};

    // Inputs only change just after a rising edge, so the values seen
    // here are the ones the next edge samples.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                logic        ov;
                logic [31:0] ey;
                logic        ir;
                logic        pop;
                logic        acc;
                logic [31:0] l;
                logic [31:0] r;
                ov = (mq[d].size() > 0);
                ey = ov ? mq[d][0] : 32'h0;
                ir = rst && ((mq[d].size() < mdep[d]) || (ov && sor));
                chk($sformatf("d%0d_out_valid", d), {31'b0, av[d]}, {31'b0, ov});
                chk($sformatf("d%0d_Y", d), ay[d], ey);
                chk($sformatf("d%0d_zero", d), {31'b0, az[d]}, {31'b0, ov && ey == 0});
                chk($sformatf("d%0d_pcnt", d), {24'b0, apc[d]}, $countones(ey));
                chk($sformatf("d%0d_in_ready", d), {31'b0, air[d]}, {31'b0, ir});
                chk($sformatf("d%0d_res_cnt", d), {16'b0, arc[d]}, {16'b0, mrc[d]});
                if (!rst) begin
                    mq[d].delete();
                    macc[d] = 32'h0;
                    mrc[d] = 16'h0;
                end else begin
                    pop = ov && sor;
                    acc = siv && ir;
                    if (pop) begin
                        void'(mq[d].pop_front());
                        mrc[d] = mrc[d] + 16'd1;
                    end
                    if (acc) begin
                        l = sae ? macc[d] : (sa & mmask[d]);
                        r = ref_op(l, sb & mmask[d], sop) & mmask[d];
                        mq[d].push_back(r);
                        macc[d] = r;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(logic iv, logic [31:0] a, logic [31:0] b,
                          logic [2:0] op, logic ae, logic ordy);
        siv = iv;
        sa  = a;
        sb  = b;
        sop = op;
        sae = ae;
        sor = ordy;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b1;
        #1;
    endtask

    initial begin
        // reset, then idle
        tick();
        chk_en = 1'b1;
        chk("rst_in_ready_low", {31'b0, if8.in_ready}, 32'd0);
        tick();
        rst = 1'b1;
        #1;
        chk("idle_in_ready8", {31'b0, if8.in_ready}, 32'd1);
        chk("idle_in_ready32", {31'b0, if32.in_ready}, 32'd1);
        chk("idle_out_valid", {31'b0, if8.out_valid}, 32'd0);
        chk("idle_Y", {24'b0, if8.Y}, 32'h00);
        chk("idle_res_cnt", {16'b0, if8.res_cnt}, 32'd0);
        chk("idle_pcnt", {28'b0, if8.pcnt}, 32'd0);

        // single AND beat
        set_in(1, 32'hF0, 32'h3C, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        chk("and_Y", {24'b0, if8.Y}, 32'h30);
        chk("and_valid", {31'b0, if8.out_valid}, 32'd1);
        chk("and_pcnt", {28'b0, if8.pcnt}, 32'd2);
        chk("and_zero", {31'b0, if8.zero}, 32'd0);
        chk("and_Y32", if32.Y, 32'h30);
        set_in(0, 0, 0, 0, 0, 1);
        tick();

        // backpressure then in-order drain
        do_reset();
        set_in(1, 32'h11, 0, 7, 0, 0);
        tick();
        set_in(1, 32'h22, 0, 7, 0, 0);
        tick();
        set_in(1, 32'h33, 0, 7, 0, 0);
        chk("bp_in_ready8", {31'b0, if8.in_ready}, 32'd0);
        chk("bp_in_ready32", {31'b0, if32.in_ready}, 32'd1);
        tick();
        set_in(1, 32'h33, 0, 7, 0, 1);
        chk("bp_pop_ready", {31'b0, if8.in_ready}, 32'd1);
        chk("bp_pop0", {24'b0, if8.Y}, 32'h11);
        tick();
        set_in(0, 0, 0, 7, 0, 1);
        chk("bp_pop1", {24'b0, if8.Y}, 32'h22);
        tick();
        chk("bp_pop2", {24'b0, if8.Y}, 32'h33);
        tick();
        chk("bp_empty", {31'b0, if8.out_valid}, 32'd0);
        chk("bp_res_cnt", {16'b0, if8.res_cnt}, 32'd3);

        // full FIFO streaming with simultaneous push and pop
        do_reset();
        set_in(1, 32'h01, 0, 7, 0, 0);
        tick();
        set_in(1, 32'h02, 0, 7, 0, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 32'(3 + i), 0, 7, 0, 1);
            chk("full_in_ready", {31'b0, if8.in_ready}, 32'd1);
            chk("full_valid", {31'b0, if8.out_valid}, 32'd1);
            chk("full_Y", {24'b0, if8.Y}, 32'(1 + i));
            tick();
        end
        set_in(0, 0, 0, 7, 0, 0);
        chk("full_head", {24'b0, if8.Y}, 32'h05);
        chk("full_still_full", {31'b0, if8.in_ready}, 32'd0);
        chk("full_res_cnt", {16'b0, if8.res_cnt}, 32'd4);

        // accumulator chain
        do_reset();
        set_in(1, 32'hFF, 32'h01, 1, 1, 1);
        tick();
        chk("acc_Y0", {24'b0, if8.Y}, 32'h01);
        set_in(1, 32'hFF, 32'h80, 1, 1, 1);
        tick();
        chk("acc_Y1", {24'b0, if8.Y}, 32'h81);
        chk("acc_Y1_32", if32.Y, 32'h81);
        set_in(1, 32'hFF, 32'h81, 2, 1, 1);
        tick();
        chk("acc_Y2", {24'b0, if8.Y}, 32'h00);
        chk("acc_zero", {31'b0, if8.zero}, 32'd1);
        chk("acc_pcnt", {28'b0, if8.pcnt}, 32'd0);
        chk("acc_valid", {31'b0, if8.out_valid}, 32'd1);
        set_in(0, 0, 0, 0, 0, 1);
        tick();

        // reset while full discards everything
        do_reset();
        set_in(1, 32'hAA, 0, 7, 0, 0);
        tick();
        set_in(1, 32'hBB, 0, 7, 0, 0);
        tick();
        set_in(1, 32'hCC, 0, 7, 0, 1);
        tick();
        chk("mid_res_cnt", {16'b0, if8.res_cnt}, 32'd1);
        rst = 1'b0;
        set_in(1, 32'hDD, 0, 7, 0, 0);
        tick();
        rst = 1'b1;
        set_in(0, 0, 0, 7, 0, 0);
        chk("mid_valid", {31'b0, if8.out_valid}, 32'd0);
        chk("mid_cnt0", {16'b0, if8.res_cnt}, 32'd0);
        chk("mid_in_ready", {31'b0, if8.in_ready}, 32'd1);
        set_in(1, 32'h55, 0, 7, 1, 0);
        tick();
        chk("mid_acc0", {24'b0, if8.Y}, 32'h00);
        chk("mid_acc0_valid", {31'b0, if8.out_valid}, 32'd1);
        chk("mid_acc0_zero", {31'b0, if8.zero}, 32'd1);
        set_in(0, 0, 0, 0, 0, 1);
        tick();

        // deeper FIFO backpressure
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 32'hA500_0000 + 32'(i), 0, 7, 0, 0);
            tick();
        end
        set_in(1, 32'hA500_0004, 0, 7, 0, 0);
        chk("d4_in_ready", {31'b0, if32.in_ready}, 32'd0);
        chk("d4_head", if32.Y, 32'hA500_0000);
        tick();
        set_in(0, 0, 0, 7, 0, 1);
        for (int i = 0; i < 4; i++) begin
            chk("d4_pop", if32.Y, 32'hA500_0000 + 32'(i));
            tick();
        end
        chk("d4_empty", {31'b0, if32.out_valid}, 32'd0);
        chk("d4_res_cnt", {16'b0, if32.res_cnt}, 32'd4);

        // random valid/ready traffic against the queue model
        for (int i = 0; i < 10000; i++) begin
            rst = ($urandom_range(0, 499) != 0);
            set_in(1'($urandom_range(0, 1)), $urandom, $urandom,
                   3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
            tick();
        end
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 1);
        repeat (6) tick();

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/logic_stream_unit.md
LOGIC_STREAM_UNIT -- requirements
Module: logic_stream_unit

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits, legal range 1..32.
REQ-002 Parameter DEPTH, default 2: result FIFO entries, power of two, at least 2.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: synchronous, active-low reset; sampled on the rising edge of clk.
REQ-005 Port a, input, WIDTH: left operand.
REQ-006 Port b, input, WIDTH: right operand.
REQ-007 Port op, input, 3: operation select.
REQ-008 Port acc_en, input, 1: when 1, the accumulator replaces a as the left operand.
REQ-009 Port in_valid, input, 1: operand beat offered.
REQ-010 Port in_ready, output, 1: the block can accept a beat this cycle.
REQ-011 Port Y, output, WIDTH: result at the FIFO head.
REQ-012 Port out_valid, output, 1: Y holds a valid result.
REQ-013 Port out_ready, input, 1: the consumer takes the head result.
REQ-014 Port zero, output, 1: head result equals 0.
REQ-015 Port pcnt, output, clog2(WIDTH+1): population count of the head result.
REQ-016 Port res_cnt, output, 16: number of results popped since reset.

Function
REQ-017 Accept: a beat is accepted when in_valid and in_ready are both 1 on a rising edge.
REQ-018 Pop: the head is popped when out_valid and out_ready are both 1 on a rising edge.
REQ-019 Left operand L is acc when acc_en=1, otherwise a; right operand R is b.
REQ-020 op encoding:
  - 0: L&R
  - 1: L|R
  - 2: L^R
  - 3: ~(L&R)
  - 4: ~(L|R)
  - 5: ~(L^R)
  - 6: L&~R
  - 7: L (pass-through)
REQ-021 The result is computed and written into the FIFO on the accept edge.
REQ-022 Latency: with an empty FIFO, out_valid=1 and Y=result in the cycle after the accept; there is no combinational in-to-out path.
REQ-023 The accumulator register acc (WIDTH bits) loads the result on every accept, regardless of acc_en.
REQ-024 The FIFO is strictly in-order; each entry is popped exactly once; there is no loss or duplication under any handshake pattern.
REQ-025 in_ready = (FIFO not full) OR (out_valid AND out_ready).
  - A push into a full FIFO is allowed only with a simultaneous pop.
REQ-026 Simultaneous push and pop: occupancy is unchanged, and the head advances to the next entry.
REQ-027 When the FIFO is empty and a push occurs, out_valid=0 in that cycle, and the new entry appears next cycle.
REQ-028 in_ready depends combinationally on out_ready only; it does not depend on in_valid.
REQ-029 Output values by FIFO state:
  - out_valid=0: Y=0, zero=0, pcnt=0.
  - out_valid=1: zero and pcnt derive combinationally from Y.
REQ-030 res_cnt increments by 1 on each pop and wraps from 0xFFFF to 0x0000.
REQ-031 Read and write pointers wrap modulo DEPTH; full and empty are distinguished by an occupancy counter of width clog2(DEPTH+1).
REQ-032 Inputs a, b, op and acc_en are ignored in cycles with no accept.

Reset
REQ-033 When reset=0 on an edge:
  - FIFO is emptied.
  - acc=0 and res_cnt=0.
  - out_valid=0, Y=0, zero=0, pcnt=0 from the following cycle.
REQ-034 in_ready=0 while reset=0, and in_ready=1 in the first cycle after reset is released.
REQ-035 Reset mid-operation discards all queued results and any beat offered in the reset cycle; no partial state survives.

Verification
REQ-036 Bench covers these scenarios (WIDTH=8, DEPTH=2 unless noted):
  - Reset, then idle -> Y=0x00, out_valid=0, res_cnt=0, in_ready=1.
  - a=0xF0, b=0x3C, op=0, accept at cycle N -> at cycle N+1: Y=0x30, out_valid=1, pcnt=2, zero=0.
  - out_ready=0, three beats offered with op=7, a=0x11/0x22/0x33 -> in_ready=0 after two accepts; with out_ready=1, pops are 0x11, 0x22, 0x33 in order; res_cnt=3.
  - FIFO full, in_valid=1, out_ready=1 held for 4 cycles -> in_ready=1 each cycle, occupancy stays 2, one result per cycle.
  - Accumulate: acc_en=1, op=1, b=0x01 then b=0x80 -> results 0x01, 0x81; then op=2, b=0x81 -> result 0x00, zero=1, pcnt=0.
  - FIFO full, reset asserted for one cycle -> next cycle out_valid=0, res_cnt=0; first accept with acc_en=1, op=7 returns 0x00.
REQ-037 Bench repeats the handshake scenarios with DEPTH=4 and WIDTH=32, and runs 10k random valid/ready cycles against a reference queue model.
